// File: rtl/dm_cache_if.sv
// -----------------------------------------------------------------------------
// dm_cache_if
//   Bus bundle between the cache, the CPU memory port and physical memory.
//
//   CPU side      : mem_read, mem_write, mem_byte_enable, mem_address,
//                   mem_wdata -> cache ; mem_rdata, mem_resp <- cache
//   Physical side : pmem_read, pmem_write, pmem_address, pmem_wdata <- cache ;
//                   pmem_rdata, pmem_resp -> cache
//
//   modport slave  : the cache's view
//   modport master : the environment's view (CPU plus physical memory)
// -----------------------------------------------------------------------------
interface dm_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dm_cache.sv
// -----------------------------------------------------------------------------
// dm_cache
//   Direct-mapped, write-back, write-allocate cache between a CPU word port
//   and a 256-bit line-wide physical memory. Tags, valid, dirty and data are
//   flop arrays read combinationally.
//
//   Ports
//     clk        : clock, all state updates on the rising edge
//     rst        : asynchronous active-high reset
//     bus        : dm_cache_if.slave (CPU request/response + line fill/writeback)
//     hit_count  : 32-bit hit counter   (only with DM_CACHE_STATS_EN)
//     miss_count : 32-bit miss counter  (only with DM_CACHE_STATS_EN)
//
//   Parameter
//     SETS_LOG2  : log2 of the number of sets
//                  tag = addr[31:5+SETS_LOG2], index = addr[4+SETS_LOG2:5],
//                  word = addr[4:2]
//
//   Build option
//     DM_CACHE_STATS_EN : adds the hit/miss counters and their ports.
// -----------------------------------------------------------------------------
module dm_cache #(
  parameter int SETS_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  dm_cache_if.slave   bus
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS  = 1 << SETS_LOG2;
  localparam int TAG_W = 27 - SETS_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WB,
    FILL
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0] tag_q  [SETS];
  logic [255:0]     data_q [SETS];
  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;

  // Address decode
  logic [TAG_W-1:0]     req_tag;
  logic [SETS_LOG2-1:0] index;
  logic [2:0]           word;
  logic [1:0]           unused_byte_offset;

  assign req_tag            = bus.mem_address[31 -: TAG_W];
  assign index              = bus.mem_address[5 +: SETS_LOG2];
  assign word               = bus.mem_address[4:2];
  assign unused_byte_offset = bus.mem_address[1:0];

  logic         req;
  logic         is_write;
  logic         hit;
  logic [255:0] cur_line;

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;  // read+write together behaves as a write
  assign cur_line = data_q[index];
  assign hit      = valid_q[index] && (tag_q[index] == req_tag);

  assign bus.mem_rdata  = cur_line[{word, 5'd0} +: 32];
  assign bus.pmem_wdata = cur_line;

  // Byte-lane merge of the CPU write into the addressed word
  logic [31:0]  merged_word;
  logic [255:0] merged_line;

  always_comb begin
    merged_word = cur_line[{word, 5'd0} +: 32];
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) merged_word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
    merged_line                     = cur_line;
    merged_line[{word, 5'd0} +: 32] = merged_word;
  end

  // Next-state and output decode
  logic         data_we;
  logic         tag_we;
  logic [255:0] data_line_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d          = state_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    data_we          = 1'b0;
    tag_we           = 1'b0;
    data_line_d      = cur_line;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit)                                  state_d = RESP;
          else if (valid_q[index] && dirty_q[index]) state_d = WB;
          else                                      state_d = FILL;
        end
      end

      RESP: begin
        bus.mem_resp = 1'b1;
        state_d      = IDLE;
        if (is_write) begin
          data_we     = 1'b1;
          data_line_d = merged_line;
          // An all-zero byte mask leaves the line bit-identical, so stays clean
          if (|bus.mem_byte_enable) dirty_d[index] = 1'b1;
        end
      end

      WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[index], index, 5'b0};
        if (bus.pmem_resp) state_d = FILL;
      end

      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_tag, index, 5'b0};
        if (bus.pmem_resp) begin
          data_we        = 1'b1;
          data_line_d    = bus.pmem_rdata;
          tag_we         = 1'b1;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, valid and dirty registers; the async reset drops the pmem strobes
  // at once because they decode straight from state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data arrays carry no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    if (data_we) data_q[index] <= data_line_d;
    if (tag_we)  tag_q[index]  <= req_tag;
  end

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        miss_pending_q, miss_pending_d;

  // A request that needed a fill re-enters IDLE and then hits; miss_pending
  // keeps that second pass from also being counted as a hit.
  always_comb begin
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    miss_pending_d = miss_pending_q;
    if (state_q == IDLE && (state_d == WB || state_d == FILL)) begin
      miss_count_d   = miss_count_q + 32'd1;
      miss_pending_d = 1'b1;
    end
    if (state_q == IDLE && state_d == RESP && !miss_pending_q) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (state_q == RESP) miss_pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      miss_pending_q <= 1'b0;
    end else begin
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      miss_pending_q <= miss_pending_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// -----------------------------------------------------------------------------
// tb_dm_cache
//   Directed self-checking bench for dm_cache. A background process models
//   physical memory with a fixed response latency; each untouched line at
//   address A holds words (A << 16) + i, so expected read data is known.
// -----------------------------------------------------------------------------
module tb_dm_cache;

  localparam int PMEM_LAT = 2;   // idle negedges before the pmem_resp pulse
  localparam int BUDGET   = 60;  // cycle bound for any single access

  logic clk;
  logic rst;

  dm_cache_if bus ();

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dm_cache #(.SETS_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- pmem model
  typedef struct {
    logic         is_write;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } pmem_op_t;

  logic [255:0] pmem_mem [logic [31:0]];
  pmem_op_t     log_q [$];
  int           rd_cycles;
  int           wr_cycles;

  function automatic logic [255:0] default_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = (a << 16) + i;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [255:0] l, input int w);
    return l[32*w +: 32];
  endfunction

  initial begin
    int       cnt;
    pmem_op_t op;
    cnt             = 0;
    bus.pmem_resp   = 1'b0;
    bus.pmem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (bus.pmem_read)  rd_cycles++;
        if (bus.pmem_write) wr_cycles++;
        if (cnt == PMEM_LAT) begin
          cnt         = 0;
          op.is_write = bus.pmem_write;
          op.addr     = bus.pmem_address;
          op.wdata    = bus.pmem_wdata;
          log_q.push_back(op);
          if (bus.pmem_write) begin
            pmem_mem[bus.pmem_address] = bus.pmem_wdata;
          end else if (pmem_mem.exists(bus.pmem_address)) begin
            bus.pmem_rdata = pmem_mem[bus.pmem_address];
          end else begin
            bus.pmem_rdata = default_line(bus.pmem_address);
          end
          bus.pmem_resp = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ------------------------------------------------------------- CPU driver
  // Drives a request just after a rising edge, returns the cycle index of
  // mem_resp (request first seen = cycle 0) or -1 when the budget runs out.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int lat, output logic [31:0] rdata);
    @(posedge clk);
    #1;
    rd_cycles           = 0;
    wr_cycles           = 0;
    log_q.delete();
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    lat                 = -1;
    rdata               = 'x;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        lat   = c;
        rdata = bus.mem_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset;
    rst                 = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp got %b exp 0", bus.mem_resp); end
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got %b exp 0", bus.pmem_read); end
    checks++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got %b exp 0", bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_addr got %h exp 0", bus.pmem_address); end
`ifdef DM_CACHE_STATS_EN
    checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL reset_hit_count got %0d exp 0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
`endif
  endtask

  task automatic test_cold_read;
    int lat; logic [31:0] rd;
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, lat, rd);
    // FILL cycles 1..3 with pmem_resp in 3, IDLE 4, RESP 5
    checks++; if (lat !== 5) begin errors++; $display("FAIL cold_latency got %0d exp 5", lat); end
    checks++; if (rd !== 32'h0100_0001) begin errors++; $display("FAIL cold_rdata got %h exp 01000001", rd); end
    checks++; if (rd_cycles !== 3) begin errors++; $display("FAIL cold_fill_cycles got %0d exp 3", rd_cycles); end
    checks++; if (wr_cycles !== 0) begin errors++; $display("FAIL cold_wb_cycles got %0d exp 0", wr_cycles); end
    checks++;
    if (log_q.size() != 1 || log_q[0].is_write !== 1'b0 || log_q[0].addr !== 32'h0000_0100) begin
      errors++; $display("FAIL cold_fill_addr got n=%0d addr %h exp 1 fill at 00000100",
                         log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 32'hx);
    end
  endtask

  task automatic test_read_hit;
    int lat; logic [31:0] rd;
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, lat, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hit_latency got %0d exp 1", lat); end
    checks++; if (rd !== 32'h0100_0001) begin errors++; $display("FAIL hit_rdata got %h exp 01000001", rd); end
    checks++; if (rd_cycles !== 0) begin errors++; $display("FAIL hit_no_fill got %0d exp 0", rd_cycles); end
`ifdef DM_CACHE_STATS_EN
    checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_count got %0d exp 1", hit_count); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL miss_count got %0d exp 1", miss_count); end
`endif
  endtask

  task automatic test_write_hit;
    int lat; logic [31:0] rd;
    // old word 2 = 01000002; lanes 0 and 2 take DD and BB -> 01BB00DD
    do_access(1'b0, 1'b1, 32'h0000_0108, 32'hAABB_CCDD, 4'b0101, lat, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got %0d exp 1", lat); end
    do_access(1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h01BB_00DD) begin errors++; $display("FAIL wr_merge got %h exp 01bb00dd", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_readback_latency got %0d exp 1", lat); end
  endtask

  task automatic test_conflict_dirty;
    int lat; logic [31:0] rd;
    do_access(1'b1, 1'b0, 32'h0000_1100, 32'h0, 4'h0, lat, rd);
    // WB 1..3, FILL 4..6, IDLE 7, RESP 8
    checks++; if (lat !== 8) begin errors++; $display("FAIL dirty_latency got %0d exp 8", lat); end
    checks++; if (rd !== 32'h1100_0000) begin errors++; $display("FAIL dirty_rdata got %h exp 11000000", rd); end
    checks++; if (wr_cycles !== 3) begin errors++; $display("FAIL dirty_wb_cycles got %0d exp 3", wr_cycles); end
    checks++; if (rd_cycles !== 3) begin errors++; $display("FAIL dirty_fill_cycles got %0d exp 3", rd_cycles); end
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL dirty_op_count got %0d exp 2", log_q.size());
    end else begin
      checks++; if (log_q[0].is_write !== 1'b1 || log_q[0].addr !== 32'h0000_0100) begin
        errors++; $display("FAIL dirty_wb_addr got w=%b %h exp w=1 00000100", log_q[0].is_write, log_q[0].addr); end
      checks++; if (word_of(log_q[0].wdata, 2) !== 32'h01BB_00DD) begin
        errors++; $display("FAIL dirty_wb_word2 got %h exp 01bb00dd", word_of(log_q[0].wdata, 2)); end
      checks++; if (word_of(log_q[0].wdata, 1) !== 32'h0100_0001) begin
        errors++; $display("FAIL dirty_wb_word1 got %h exp 01000001", word_of(log_q[0].wdata, 1)); end
      checks++; if (log_q[1].is_write !== 1'b0 || log_q[1].addr !== 32'h0000_1100) begin
        errors++; $display("FAIL dirty_fill_addr got w=%b %h exp w=0 00001100", log_q[1].is_write, log_q[1].addr); end
    end
    // The written-back line must come back from memory with the merge intact
    do_access(1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0, lat, rd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL refetch_latency got %0d exp 5", lat); end
    checks++; if (rd !== 32'h01BB_00DD) begin errors++; $display("FAIL refetch_rdata got %h exp 01bb00dd", rd); end
    checks++; if (wr_cycles !== 0) begin errors++; $display("FAIL refetch_no_wb got %0d exp 0", wr_cycles); end
  endtask

  task automatic test_reset_mid_fill;
    int lat; logic [31:0] rd; logic seen;
    @(posedge clk);
    #1;
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b0;
    bus.mem_address = 32'h0000_3104;
    seen = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (bus.pmem_read === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstfill_enter got %b exp 1", seen); end
    #2 rst = 1'b1;
    bus.mem_read = 1'b0;
    #1;
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rstfill_pmem_read got %b exp 0", bus.pmem_read); end
    checks++; if (bus.pmem_address !== 32'h0) begin errors++; $display("FAIL rstfill_pmem_addr got %h exp 0", bus.pmem_address); end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    do_access(1'b1, 1'b0, 32'h0000_3104, 32'h0, 4'h0, lat, rd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstfill_remiss got %0d exp 5", lat); end
    checks++; if (rd !== 32'h3100_0001) begin errors++; $display("FAIL rstfill_rdata got %h exp 31000001", rd); end
  endtask

  task automatic test_zero_be_write;
    int lat; logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h0000_3104, 32'hFFFF_FFFF, 4'b0000, lat, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zbe_latency got %0d exp 1", lat); end
    do_access(1'b1, 1'b0, 32'h0000_3104, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h3100_0001) begin errors++; $display("FAIL zbe_unchanged got %h exp 31000001", rd); end
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, lat, rd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL zbe_conflict_latency got %0d exp 5", lat); end
    checks++; if (wr_cycles !== 0) begin errors++; $display("FAIL zbe_no_wb got %0d exp 0", wr_cycles); end
    checks++; if (rd !== 32'h0100_0001) begin errors++; $display("FAIL zbe_conflict_rdata got %h exp 01000001", rd); end
  endtask

  task automatic test_both_strobes;
    int lat; logic [31:0] rd;
    // index 1, cold: fill then write of the full word
    do_access(1'b1, 1'b1, 32'h0000_2024, 32'h1234_5678, 4'b1111, lat, rd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rw_latency got %0d exp 5", lat); end
    do_access(1'b1, 1'b0, 32'h0000_2024, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rw_as_write got %h exp 12345678", rd); end
    do_access(1'b1, 1'b0, 32'h0000_2020, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h2020_0000) begin errors++; $display("FAIL rw_neighbour got %h exp 20200000", rd); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit();
    test_conflict_dirty();
    test_reset_mid_fill();
    test_zero_be_write();
    test_both_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
